// File: rtl/mem_responder.sv
// Memory bus target: DEPTH x DATA_WIDTH array cleared after every reset,
// registered one-cycle read data on a tri-stated bus, saturating counters, sticky conflict flag.
module mem_responder #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int INIT_VALUE = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output tri   [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  conflict_err,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {INIT, IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rd_valid;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  // Single array write port shared by the post-reset clear and bus writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr;
    mem_wd = data_in;
    if (state == INIT) begin
      mem_we = 1'b1;
      mem_wa = clr_ptr;
      mem_wd = DATA_WIDTH'(INIT_VALUE);
    end else if (write && !read) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= INIT;
      clr_ptr      <= '0;
      busy         <= 1'b1;
      rd_valid     <= 1'b0;
      rdata_q      <= '0;
      conflict_err <= 1'b0;
      wr_count     <= '0;
      rd_count     <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          // Conditions written so an X on read/write falls through to no access.
          if (read && write) begin
            conflict_err <= 1'b1;
          end else if (read && !write) begin
            rdata_q  <= mem[addr];
            rd_valid <= 1'b1;
            if (rd_count != '1) rd_count <= rd_count + 1'b1;
          end else if (write && !read) begin
            if (wr_count != '1) wr_count <= wr_count + 1'b1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign data_out = rd_valid ? rdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder against a queue/array-level model;
// a CNT_WIDTH=4 twin shares the inputs to exercise counter saturation.
module tb_mem_responder;
  logic       clk, rst, read, write;
  logic [4:0] addr;
  logic [7:0] data_in;
  wire  [7:0] data_out, dout4;
  logic       busy, conflict_err, busy4, conf4;
  logic [15:0] wr_count, rd_count;
  logic [3:0]  wr4, rd4;

  mem_responder dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(data_out), .busy(busy), .conflict_err(conflict_err),
    .wr_count(wr_count), .rd_count(rd_count));

  mem_responder #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(dout4), .busy(busy4), .conflict_err(conf4),
    .wr_count(wr4), .rd_count(rd4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_z(string nm, bit is_z, logic [7:0] act);
    n_tests++;
    if (!is_z) begin
      n_fail++;
      $display("FAIL %s: got %0h expected high-Z at %0t", nm, act, $time);
    end
  endtask

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  // ---------------- behavioural model ----------------
  int         clear_left;
  logic [7:0] mmem [32];
  bit         mconf, exp_dv;
  logic [7:0] exp_do;
  int         mwr, mrd;

  task automatic mreset();
    clear_left = 32;
    foreach (mmem[i]) mmem[i] = 8'h00;
    mconf = 0; mwr = 0; mrd = 0; exp_dv = 0; exp_do = 8'h00;
  endtask

  always @(posedge rst) mreset();

  always @(posedge clk) begin
    if (rst) mreset();
    else if (clear_left > 0) begin
      clear_left--;
      exp_dv = 0;
    end else if (read === 1'b1 && write === 1'b1) begin
      mconf = 1; exp_dv = 0;
    end else if (read === 1'b1) begin
      exp_do = mmem[addr]; exp_dv = 1; mrd++;
    end else begin
      exp_dv = 0;
      if (write === 1'b1) begin
        mmem[addr] = data_in; mwr++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("busy", busy, clear_left > 0);
      chk("busy4", busy4, clear_left > 0);
      chk("conflict_err", conflict_err, mconf);
      chk("wr_count", wr_count, sat(mwr, 65535));
      chk("rd_count", rd_count, sat(mrd, 65535));
      chk("wr_count4", wr4, sat(mwr, 15));
      chk("rd_count4", rd4, sat(mrd, 15));
      if (exp_dv) chk("data_out", data_out, exp_do);
      else        chk_z("data_out_z", data_out === 8'bz, data_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(bit r, bit w, logic [4:0] a, logic [7:0] d);
    read = r; write = w; addr = a; data_in = d;
    @(negedge clk);
  endtask

  // Called at a negedge with rst high; releases it and waits out the clear.
  task automatic release_init(bit junk);
    int n;
    read = 0; write = 0;
    @(negedge clk);
    rst = 0;
    n = 0;
    while (busy && n < 100) begin
      if (junk && n < 10) begin write = 1; addr = 5'd3; data_in = 8'hAA; end
      else write = 0;
      @(negedge clk);
      n++;
    end
    write = 0;
    chk("init_cycles", n, 32);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    release_init(0);
  endtask

  initial begin
    rst = 1; read = 0; write = 0; addr = 0; data_in = 0;
    @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_conflict", conflict_err, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
    chk_z("rst_data_out", data_out === 8'bz, data_out);
    @(negedge clk);
    chk_en = 1;

    // Reset and clear, with ignored writes during the clear.
    release_init(1);
    chk("clear_wr_count", wr_count, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 5'(i), 8'h00);
      chk("clear_read", data_out, 8'h00);
    end
    cyc(0, 0, 0, 0);
    chk_z("clear_idle_z", data_out === 8'bz, data_out);

    // Data = address.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 5'(i), 8'(i));
      chk_z("wr_z", data_out === 8'bz, data_out);
    end
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 5'(i), 8'h00);
      chk("data_eq_addr", data_out, i);
    end
    chk("da_wr_count", wr_count, 32);
    chk("da_rd_count", rd_count, 32);
    cyc(0, 0, 0, 0);
    chk_z("da_idle_z", data_out === 8'bz, data_out);

    // Back-to-back reads.
    begin
      logic [15:0] r0;
      cyc(0, 1, 5'd5, 8'h11);
      cyc(0, 1, 5'd6, 8'h22);
      r0 = rd_count;
      cyc(1, 0, 5'd5, 8'h00);
      chk("b2b_first", data_out, 8'h11);
      cyc(1, 0, 5'd6, 8'h00);
      chk("b2b_second", data_out, 8'h22);
      chk("b2b_rd_count", rd_count, r0 + 16'd2);
      cyc(0, 0, 0, 0);
    end

    // Conflict.
    begin
      logic [15:0] w0, r0;
      cyc(0, 1, 5'd7, 8'h33);
      w0 = wr_count; r0 = rd_count;
      cyc(1, 1, 5'd7, 8'hFF);
      chk("conf_flag", conflict_err, 1);
      chk_z("conf_z", data_out === 8'bz, data_out);
      cyc(1, 0, 5'd7, 8'h00);
      chk("conf_read", data_out, 8'h33);
      cyc(0, 0, 0, 0);
      chk("conf_sticky", conflict_err, 1);
      chk("conf_wr_count", wr_count, w0);
      chk("conf_rd_count", rd_count, r0 + 16'd1);
    end

    // Reset in the middle of a read.
    cyc(0, 1, 5'd9, 8'h55);
    cyc(1, 0, 5'd9, 8'h00);
    chk("mid_pre", data_out, 8'h55);
    #2 rst = 1;
    #1;
    chk_z("mid_async_z", data_out === 8'bz, data_out);
    chk("mid_async_conf", conflict_err, 0);
    chk("mid_async_busy", busy, 1);
    release_init(0);
    cyc(1, 0, 5'd9, 8'h00);
    chk("mid_reread", data_out, 8'h00);
    cyc(0, 0, 0, 0);

    // Saturation on the 4-bit twin.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 5'(i), 8'(i + 8'h40));
      chk("sat_step", wr4, sat(i + 1, 15));
    end
    chk("sat_wr4", wr4, 4'hF);
    chk("sat_wr16", wr_count, 20);
    cyc(0, 0, 0, 0);
    chk("sat_hold", wr4, 4'hF);

    // Randomized traffic, with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 4) begin
        do_reset();
      end else begin
        r = r % 100;
        if (r < 3)       cyc(1, 1, 5'($urandom), 8'($urandom));
        else if (r < 40) cyc(1, 0, 5'($urandom), 8'($urandom));
        else if (r < 75) cyc(0, 1, 5'($urandom), 8'($urandom));
        else             cyc(0, 0, 5'($urandom), 8'($urandom));
      end
    end
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target side of the single-port memory bus (read, write, addr, data_in, data_out) driven by the memory test initiator.
- Holds a DEPTH x DATA_WIDTH storage array, DEPTH = 2**ADDR_WIDTH (32 x 8 at defaults).
- Self-clears the array after every reset.
- Returns registered read data on a tri-stated bus.
- Keeps transaction counters and a sticky protocol-error flag for the bench.

Parameters:
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data word width.
- INIT_VALUE, 0, value written to every location during post-reset clear.
- CNT_WIDTH, 16, width of the read and write transaction counters.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- read  input  1  read request, sampled at posedge.
- write  input  1  write request, sampled at posedge.
- addr  input  ADDR_WIDTH  location for the current read or write.
- data_in  input  DATA_WIDTH  write data.
- data_out  output (tri)  DATA_WIDTH  read data; high-Z when not presenting data.
- busy  output  1  high while post-reset clear runs; requests are ignored.
- conflict_err  output  1  sticky: read and write were sampled high together.
- wr_count  output  CNT_WIDTH  accepted writes, saturating.
- rd_count  output  CNT_WIDTH  accepted reads, saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State = INIT, clr_ptr = 0, busy = 1, data_out = Z, rd_valid = 0.
  - conflict_err = 0, wr_count = 0, rd_count = 0.
  - Array contents are don't-care until INIT completes.
- INIT:
  - Each posedge writes INIT_VALUE to mem[clr_ptr] and increments clr_ptr.
  - On the edge that writes DEPTH-1, go to IDLE; busy falls after that edge.
  - Total clear time is exactly DEPTH cycles after rst deasserts (32 at defaults).
  - read and write are ignored (no access, no count, no error).
- IDLE, posedge with write=1 and read=0:
  - mem[addr] <= data_in; wr_count increments (holds at all-ones).
  - New data is readable by any read sampled on a later edge.
- IDLE, posedge with read=1 and write=0:
  - rdata_q <= mem[addr]; rd_valid <= 1; rd_count increments (saturating).
  - data_out = rdata_q while rd_valid = 1, otherwise Z.
  - Data is stable from that posedge to the next posedge, so it is valid at the initiator's following negedge sample point.
  - One-cycle read latency.
- Back-to-back reads (read held high): data_out updates each edge to the currently addressed word; one count per edge.
- Posedge with read=0: rd_valid <= 0, so data_out goes Z after that edge.
- Posedge with read=1 and write=1:
  - No array access, no count change, rd_valid <= 0.
  - conflict_err <= 1, held until rst.
- addr is always in range, since its width equals the index width; there is no wrap logic.
- Counter saturation: at all-ones a counter holds; no rollover to 0.
- Reset mid-operation (during INIT, a read, or a write):
  - The in-flight write is not guaranteed.
  - data_out goes Z immediately.
  - Array clear restarts from location 0 after rst deasserts.
- X on read or write while in IDLE: treated as 0; no access.

Test Plan:
- Reset and clear:
  - Stimulus: pulse rst, write 8'hAA to addr 3 during the first 10 cycles, then read all 32 addresses after busy falls.
  - Required: busy high for exactly 32 cycles; every location reads 8'h00; wr_count = 0.
- Data = address:
  - Stimulus: write i to addr i for i = 0..31, then read 0..31 sampling data_out at the negedge after read is asserted.
  - Required: each read returns i; wr_count = 32, rd_count = 32; data_out is Z whenever read = 0.
- Back-to-back reads:
  - Stimulus: after writing 8'h11 to addr 5 and 8'h22 to addr 6, hold read = 1 with addr = 5 then 6 on consecutive cycles.
  - Required: data_out = 8'h11 then 8'h22 on consecutive cycles; rd_count increases by 2.
- Conflict:
  - Stimulus: addr 7 holds 8'h33; assert read = write = 1 with data_in = 8'hFF for one cycle; then do a normal read of addr 7.
  - Required: conflict_err = 1 and stays 1; read returns 8'h33; counters show only the one normal read.
- Reset mid-read:
  - Stimulus: assert rst asynchronously while data_out is presenting 8'h55.
  - Required: data_out goes Z and conflict_err clears without waiting for a clock edge; after re-init, the address reads 8'h00.
- Saturation:
  - Stimulus: CNT_WIDTH = 4, perform 20 writes.
  - Required: wr_count = 4'hF and holds at 4'hF.
